// File: rtl/kw11l_wb.sv
// KW11-L line clock: Wishbone CSR (MON/IE) plus a vectored interrupt handshake.
// Define KW11L_TICK_GEN_EN to derive the 50 Hz tick internally from clk_p.
module kw11l_wb #(
    parameter logic [15:0] VECTOR = 16'o100,
    parameter int          CLK_HZ = 50000000
) (
    input  logic        clk_p,
    input  logic        rst_n,
    input  logic        init_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        tick_i,
    output logic        irq_o,
    input  logic        istb_i,
    output logic [15:0] ivec_o,
    output logic        iack_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_ack, r_mon, r_ie;
    logic [15:0] r_dat;
    logic        w_tick, w_cs, w_start, w_wr, w_ie_nxt, w_unused;

`ifdef KW11L_TICK_GEN_EN
    localparam int          DIV = CLK_HZ / 50;
    localparam logic [20:0] TC  = 21'(DIV - 1);

    // Free-running divider; only rst_n clears it so bus init does not skew the tick phase.
    logic [20:0] r_div;
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n)           r_div <= '0;
        else if (r_div == TC) r_div <= '0;
        else                  r_div <= r_div + 21'd1;
    end
    assign w_tick   = (r_div == TC);
    assign w_unused = &{1'b0, tick_i, wb_sel_i[1], wb_dat_i[15:8], wb_dat_i[5:0]};
`else
    localparam logic [31:0] L_HZ = CLK_HZ;
    assign w_tick   = tick_i;
    assign w_unused = &{1'b0, L_HZ, wb_sel_i[1], wb_dat_i[15:8], wb_dat_i[5:0]};
`endif

    // A transaction starts on the first cycle stb is seen without ack; writes land only then.
    assign w_cs     = wb_cyc_i & wb_stb_i;
    assign w_start  = w_cs & ~r_ack;
    assign w_wr     = w_start & wb_we_i & wb_sel_i[0];
    assign w_ie_nxt = w_wr ? wb_dat_i[6] : r_ie;

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_mon <= 1'b0;
            r_ie  <= 1'b0;
        end else if (init_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_mon <= 1'b0;
            r_ie  <= 1'b0;
        end else begin
            r_ack <= w_cs;
            if (w_start)    r_dat <= {8'o0, r_mon, r_ie, 6'o0};
            else if (!w_cs) r_dat <= '0;
            r_ie <= w_ie_nxt;
            if (w_tick)                   r_mon <= 1'b1;
            else if (w_wr && !wb_dat_i[7]) r_mon <= 1'b0;
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n)      r_state <= S_IDLE;
        else if (init_i) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_tick && w_ie_nxt) w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_wr && !wb_dat_i[6]) w_state_nxt = S_IDLE;
                else if (istb_i)          w_state_nxt = S_ACK;
            end
            S_ACK:   if (!istb_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign irq_o    = (r_state == S_REQ);
    assign iack_o   = (r_state == S_ACK);
    assign ivec_o   = (r_state == S_ACK) ? VECTOR : 16'o0;

endmodule
